spi_master_mmio: RTL and testbench

Memory-mapped SPI master peripheral for the processor's MMIO bus, successor to the fixed single-byte, mode-0, loop-back SPI shifter. Adds parametrised TX/RX FIFOs, a programmable SCK divider, all four CPOL/CPHA modes, chip-select modes and a real MISO input. Sits beside the BRAM on the request/response bus at base address BASE and answers every request it decodes with a registered response one cycle later.

---
 rtl/spi_master_pkg.sv | 27 ++
 rtl/spi_master_mmio_fifo.sv | 51 +++++
 rtl/spi_master_mmio.sv | 243 ++++++++++++++++++++++++
 tb/tb_spi_master_mmio.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master peripheral: register map, chip-select modes
// and the states of the shift engine.
package spi_master_pkg;

   localparam logic [7:0] OFF_SCKDIV  = 8'h00;
   localparam logic [7:0] OFF_SCKMODE = 8'h04;
   localparam logic [7:0] OFF_CSMODE  = 8'h18;
   localparam logic [7:0] OFF_TXDATA  = 8'h48;
   localparam logic [7:0] OFF_RXDATA  = 8'h4C;

   localparam logic [1:0] CS_AUTO = 2'd0;
   localparam logic [1:0] CS_HOLD = 2'd2;
   localparam logic [1:0] CS_OFF  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP
   } state_e;

   // Encoding 1 is not a distinct mode and behaves like AUTO.
   function automatic logic cs_is_auto(input logic [1:0] mode);
      return !mode[1];
   endfunction

endpackage

// File: rtl/spi_master_mmio_fifo.sv
// Synchronous FIFO with first-word fall-through read; pointers carry an extra wrap
// bit so full and empty are distinguishable without a separate counter.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             push_ok, pop_ok;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign count_o = wr_q - rd_q;
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
   assign rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_q[AW-1:0]] <= din_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

endmodule

// File: rtl/spi_master_mmio.sv
// MMIO SPI master: register window with registered responses, TX/RX byte FIFOs and a
// half-period driven shift engine supporting all CPOL/CPHA modes and three CS modes.
module spi_master_mmio
   import spi_master_pkg::*;
#(
   parameter logic [31:0] BASE       = 32'h10024000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          DIV_W      = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rq_en,
   input  logic [31:0] rq_addr,
   input  logic        rq_iswrite,
   input  logic [31:0] rq_data,
   output logic        rs_en,
   output logic [31:0] rs_data,
   output logic        spi_sck,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic             hit, bus_wr, bus_rd;
   logic [7:0]       off;
   logic             tx_push, rx_pop;
   logic [31:0]      rs_data_d;
   logic             rs_en_q;
   logic [31:0]      rs_data_q;

   logic [DIV_W-1:0] sckdiv_q;
   logic             cpha_q, cpol_q;
   logic [1:0]       csmode_q;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d, div_f_q, div_f_d;
   logic [3:0]       edge_q, edge_d;
   logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic             sck_q, sck_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
   logic             cpol_f_q, cpol_f_d, cpha_f_q, cpha_f_d;
   logic             start, rx_push, half_done, lead;
   logic [7:0]       rx_byte;

   logic [7:0]       tx_dout, rx_dout;
   logic             tx_full, tx_empty, rx_empty;
   logic             rx_full_unused;
   logic [CW-1:0]    tx_count_unused, rx_count_unused;
   logic [23:0]      rq_data_unused;

   assign rq_data_unused = rq_data[31:8];

   assign hit     = rq_en && (rq_addr[31:8] == BASE[31:8]);
   assign off     = rq_addr[7:0];
   assign bus_wr  = hit && rq_iswrite;
   assign bus_rd  = hit && !rq_iswrite;
   assign tx_push = bus_wr && (off == OFF_TXDATA);
   assign rx_pop  = bus_rd && (off == OFF_RXDATA) && !rx_empty;

   // Status bits are taken from the FIFO state before this request acts on it.
   always_comb begin
      rs_data_d = '0;
      if (bus_rd) begin
         case (off)
            OFF_SCKDIV:  rs_data_d = 32'(sckdiv_q);
            OFF_SCKMODE: rs_data_d = {30'b0, cpol_q, cpha_q};
            OFF_CSMODE:  rs_data_d = {30'b0, csmode_q};
            OFF_TXDATA:  rs_data_d = {tx_full, 31'b0};
            OFF_RXDATA:  rs_data_d = rx_empty ? 32'h8000_0000 : {24'b0, rx_dout};
            default:     rs_data_d = '0;
         endcase
      end
   end

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (tx_push),
      .din_i   (rq_data[7:0]),
      .pop_i   (start),
      .dout_o  (tx_dout),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count_unused)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (rx_push),
      .din_i   (rx_byte),
      .pop_i   (rx_pop),
      .dout_o  (rx_dout),
      .full_o  (rx_full_unused),
      .empty_o (rx_empty),
      .count_o (rx_count_unused)
   );

   assign half_done = (cnt_q == div_f_q);
   assign lead      = !edge_q[0];
   // With CPHA=1 the last sample lands in the same cycle the byte is pushed.
   assign rx_byte   = cpha_f_q ? {rx_sh_q[6:0], spi_miso} : rx_sh_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      edge_d   = edge_q;
      sck_d    = sck_q;
      cs_n_d   = cs_n_q;
      mosi_d   = mosi_q;
      tx_sh_d  = tx_sh_q;
      rx_sh_d  = rx_sh_q;
      div_f_d  = div_f_q;
      cpol_f_d = cpol_f_q;
      cpha_f_d = cpha_f_q;
      start    = 1'b0;
      rx_push  = 1'b0;

      if (state_q != ST_IDLE) begin
         cnt_d = half_done ? '0 : cnt_q + DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            sck_d = cpol_q;
            if (csmode_q != CS_HOLD) cs_n_d = 1'b1;
            if (!tx_empty) begin
               start = 1'b1;
               if (csmode_q == CS_HOLD && !cs_n_q) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_SETUP;
                  cs_n_d  = (csmode_q == CS_OFF);
               end
            end
         end
         ST_SETUP: begin
            if (half_done) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (half_done) begin
               sck_d  = ~sck_q;
               edge_d = edge_q + 4'd1;
               if (lead ^ cpha_f_q) begin
                  rx_sh_d = {rx_sh_q[6:0], spi_miso};
               end else begin
                  mosi_d  = cpha_f_q ? tx_sh_q[7] : tx_sh_q[6];
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
               end
               if (edge_q == 4'd15) begin
                  rx_push = 1'b1;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (half_done) begin
               if (!tx_empty) begin
                  // AUTO mode spends one extra gap half-period with CS released.
                  if (cs_is_auto(csmode_q) && !cs_n_q) begin
                     cs_n_d = 1'b1;
                  end else begin
                     start = 1'b1;
                     if (cs_is_auto(csmode_q)) begin
                        state_d = ST_SETUP;
                        cs_n_d  = 1'b0;
                     end else begin
                        state_d = ST_SHIFT;
                     end
                  end
               end else begin
                  state_d = ST_IDLE;
                  if (csmode_q != CS_HOLD) cs_n_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start) begin
         div_f_d  = sckdiv_q;
         cpol_f_d = cpol_q;
         cpha_f_d = cpha_q;
         tx_sh_d  = tx_dout;
         sck_d    = cpol_q;
         cnt_d    = '0;
         edge_d   = '0;
         if (!cpha_q) mosi_d = tx_dout[7];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs_en_q   <= 1'b0;
         rs_data_q <= '0;
         sckdiv_q  <= DIV_W'(3);
         cpha_q    <= 1'b0;
         cpol_q    <= 1'b0;
         csmode_q  <= CS_AUTO;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         edge_q    <= '0;
         div_f_q   <= '0;
         cpol_f_q  <= 1'b0;
         cpha_f_q  <= 1'b0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         sck_q     <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         rs_en_q   <= hit;
         rs_data_q <= rs_data_d;
         if (bus_wr) begin
            case (off)
               OFF_SCKDIV:  sckdiv_q <= rq_data[DIV_W-1:0];
               OFF_SCKMODE: {cpol_q, cpha_q} <= rq_data[1:0];
               OFF_CSMODE:  csmode_q <= rq_data[1:0];
               default: ;
            endcase
         end
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         edge_q   <= edge_d;
         div_f_q  <= div_f_d;
         cpol_f_q <= cpol_f_d;
         cpha_f_q <= cpha_f_d;
         tx_sh_q  <= tx_sh_d;
         rx_sh_q  <= rx_sh_d;
         sck_q    <= sck_d;
         cs_n_q   <= cs_n_d;
         mosi_q   <= mosi_d;
      end
   end

   assign rs_en    = rs_en_q;
   assign rs_data  = rs_data_q;
   assign spi_sck  = sck_q;
   assign spi_cs_n = cs_n_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_mmio.sv
// Directed bench for spi_master_mmio: bus responses go through a scoreboard queue,
// SPI pin behaviour is checked inline against hand-computed values.
module tb_spi_master_mmio;

   localparam logic [31:0] BASE = 32'h10024000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rq_en = 1'b0;
   logic [31:0] rq_addr = '0;
   logic        rq_iswrite = 1'b0;
   logic [31:0] rq_data = '0;
   logic        rs_en;
   logic [31:0] rs_data;
   logic        spi_sck, spi_cs_n, spi_mosi, spi_miso;

   logic        loop_en = 1'b0;
   logic        drv_en = 1'b0;
   logic        miso_drv = 1'b0;
   logic [7:0]  drv_pat = 8'h3C;
   int          drv_idx = 7;

   int n_checks = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   int   cs_falls = 0;
   int   sck_tog = 0;
   logic cs_prev = 1'b1;
   logic sck_prev = 1'b0;

   assign spi_miso = loop_en ? spi_mosi : miso_drv;

   always #5 clk = ~clk;

   spi_master_mmio #(.BASE(BASE), .FIFO_DEPTH(8), .DIV_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .rq_en      (rq_en),
      .rq_addr    (rq_addr),
      .rq_iswrite (rq_iswrite),
      .rq_data    (rq_data),
      .rs_en      (rs_en),
      .rs_data    (rs_data),
      .spi_sck    (spi_sck),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h, want %08h", nm, act, exp);
   endtask

   // Scoreboard monitor: every response pops one expected value.
   always @(negedge clk) begin
      if (rs_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rs_unexpected: got response %08h, want none", rs_data);
         end else begin
            automatic logic [31:0] e = exp_q.pop_front();
            automatic string nm = name_q.pop_front();
            $display("rsp %s data=%08h", nm, rs_data);
            check(nm, rs_data, e);
         end
      end
   end

   always @(negedge clk) begin
      if (cs_prev && !spi_cs_n) cs_falls++;
      cs_prev = spi_cs_n;
      if (spi_sck !== sck_prev) sck_tog++;
      sck_prev = spi_sck;
   end

   // Slave model for the mode-3 test: change data on the falling (leading) edge.
   always @(negedge spi_sck) begin
      if (drv_en && drv_idx >= 0) begin
         miso_drv = drv_pat[drv_idx];
         drv_idx--;
      end
   end

   task automatic bus_req(input bit w, input logic [7:0] o, input logic [31:0] d,
                          input logic [31:0] e, input string nm);
      @(negedge clk);
      rq_en = 1'b1; rq_iswrite = w; rq_addr = BASE + 32'(o); rq_data = d;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic bus_idle();
      @(negedge clk);
      rq_en = 1'b0; rq_iswrite = 1'b0;
   endtask

   task automatic wr(input logic [7:0] o, input logic [31:0] d);
      bus_req(1'b1, o, d, 32'h0, "write_resp");
      bus_idle();
   endtask

   task automatic rd(input logic [7:0] o, input logic [31:0] e, input string nm);
      bus_req(1'b0, o, 32'h0, e, nm);
      bus_idle();
   endtask

   task automatic frame_cap(input logic idle, output logic [7:0] bits, output int n_rise,
                            output int cs_low, output int sck_act);
      int   guard;
      logic prev;
      bits = '0; n_rise = 0; cs_low = 0; sck_act = 0; guard = 0;
      while (spi_cs_n && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check("cs_assert", 32'(spi_cs_n), 32'h0);
      prev = spi_sck;
      guard = 0;
      while (!spi_cs_n && guard < 5000) begin
         cs_low++;
         if (spi_sck !== idle) sck_act++;
         if (spi_sck && !prev) begin
            bits = {bits[6:0], spi_mosi};
            n_rise++;
         end
         prev = spi_sck;
         @(negedge clk);
         guard++;
      end
   endtask

   initial begin
      logic [7:0] bits;
      int n_rise, cs_low, sck_act, base, guard, cs_high;

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_sck", 32'(spi_sck), 32'h0);
      check("reset_cs_n", 32'(spi_cs_n), 32'h1);
      check("reset_mosi", 32'(spi_mosi), 32'h0);
      check("reset_rs_en", 32'(rs_en), 32'h0);
      rd(8'h00, 32'h3, "sckdiv_reset");
      rd(8'h4C, 32'h8000_0000, "rx_empty_reset");
      rd(8'h04, 32'h0, "sckmode_reset");
      rd(8'h18, 32'h0, "csmode_reset");
      rd(8'h48, 32'h0, "tx_not_full_reset");
      rd(8'h10, 32'h0, "unmapped_read");
      // Request outside the window must not produce a response.
      @(negedge clk);
      rq_en = 1'b1; rq_iswrite = 1'b0; rq_addr = BASE + 32'h100;
      bus_idle();

      // Mode 0, SCKDIV=0, loop-back
      loop_en = 1'b1;
      wr(8'h00, 32'h0);
      wr(8'h48, 32'hA5);
      frame_cap(1'b0, bits, n_rise, cs_low, sck_act);
      check("m0_mosi_bits", 32'(bits), 32'hA5);
      check("m0_rising_edges", 32'(n_rise), 32'd8);
      check("m0_cs_low_cycles", 32'(cs_low), 32'd18);
      check("m0_sck_high_cycles", 32'(sck_act), 32'd8);
      rd(8'h4C, 32'h0000_00A5, "m0_rx_byte");
      rd(8'h4C, 32'h8000_0000, "m0_rx_empty");

      // Mode 3, SCKDIV=2, MISO from slave model
      loop_en = 1'b0;
      wr(8'h00, 32'h2);
      wr(8'h04, 32'h3);
      @(negedge clk);
      check("m3_sck_idle_high", 32'(spi_sck), 32'h1);
      drv_en = 1'b1;
      wr(8'h48, 32'hFF);
      frame_cap(1'b1, bits, n_rise, cs_low, sck_act);
      drv_en = 1'b0;
      check("m3_cs_low_cycles", 32'(cs_low), 32'd54);
      check("m3_sck_low_cycles", 32'(sck_act), 32'd24);
      rd(8'h4C, 32'h0000_003C, "m3_rx_byte");

      // TX overflow at maximum divider (31 with a 5-bit divider)
      wr(8'h04, 32'h0);
      wr(8'h00, 32'hFFFF_FFFF);
      loop_en = 1'b1;
      base = cs_falls;
      for (int i = 0; i < 7; i++) bus_req(1'b1, 8'h48, 32'h10 + 32'(i), 32'h0, "ovf_push");
      bus_req(1'b0, 8'h48, 32'h0, 32'h0, "ovf_tx_not_full");
      for (int i = 7; i < 10; i++) bus_req(1'b1, 8'h48, 32'h10 + 32'(i), 32'h0, "ovf_push");
      bus_req(1'b0, 8'h48, 32'h0, 32'h8000_0000, "ovf_tx_full");
      bus_idle();
      repeat (6500) @(negedge clk);
      check("ovf_frame_count", 32'(cs_falls - base), 32'd9);
      rd(8'h48, 32'h0, "ovf_tx_drained");
      for (int i = 0; i < 8; i++) rd(8'h4C, 32'h10 + 32'(i), "ovf_rx_byte");
      rd(8'h4C, 32'h8000_0000, "ovf_rx_empty");

      // CSMODE=HOLD across two frames
      wr(8'h00, 32'h1);
      wr(8'h18, 32'h2);
      bus_req(1'b1, 8'h48, 32'h5A, 32'h0, "hold_push");
      bus_req(1'b1, 8'h48, 32'hC3, 32'h0, "hold_push");
      bus_idle();
      guard = 0;
      while (spi_cs_n && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      cs_high = 0;
      for (int i = 0; i < 100; i++) begin
         if (spi_cs_n) cs_high++;
         @(negedge clk);
      end
      check("hold_cs_high_cycles", 32'(cs_high), 32'd0);
      check("hold_cs_after", 32'(spi_cs_n), 32'h0);
      rd(8'h4C, 32'h5A, "hold_rx_byte0");
      rd(8'h4C, 32'hC3, "hold_rx_byte1");
      bus_req(1'b1, 8'h18, 32'h0, 32'h0, "hold_release");
      bus_idle();
      @(negedge clk);
      check("hold_cs_release", 32'(spi_cs_n), 32'h1);

      // Reset during the 5th edge of the second frame
      wr(8'h00, 32'h3);
      base = sck_tog;
      bus_req(1'b1, 8'h48, 32'h81, 32'h0, "rst_push");
      bus_req(1'b1, 8'h48, 32'hFF, 32'h0, "rst_push");
      bus_idle();
      guard = 0;
      while ((sck_tog - base) < 21 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("rst_edge_reached", 32'(sck_tog - base), 32'd21);
      #1 reset = 1'b1;
      #1;
      check("rst_async_sck", 32'(spi_sck), 32'h0);
      check("rst_async_cs_n", 32'(spi_cs_n), 32'h1);
      check("rst_async_mosi", 32'(spi_mosi), 32'h0);
      check("rst_async_rs_en", 32'(rs_en), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rd(8'h4C, 32'h8000_0000, "rst_rx_lost");
      rd(8'h00, 32'h3, "rst_sckdiv");

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
